// File: rtl/tensor_core_sequencer_pkg.sv
// Shared types and constants for the tensor core sequencer: FSM states,
// opcode encodings, default element width and row-major index helpers.
package tensor_core_sequencer_pkg;

  localparam int BUS_WIDTH = 7;

  localparam logic [2:0] OP_MATMUL = 3'd0;
  localparam logic [2:0] OP_ADD    = 3'd1;
  localparam logic [2:0] OP_RELU   = 3'd2;

  localparam logic [3:0] LAST_ELEM = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    COMPUTE,
    DRAIN
  } seqState_t;

  // Row-major 3x3 mapping of a flat element index k -> [k/3][k%3]
  function automatic logic [1:0] elemRow(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: elemRow = 2'd0;
      4'd3, 4'd4, 4'd5: elemRow = 2'd1;
      default:          elemRow = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] elemCol(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: elemCol = 2'd0;
      4'd1, 4'd4, 4'd7: elemCol = 2'd1;
      default:          elemCol = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/tensor_core_sequencer_if.sv
// Bundles the byte input stream, the tensor core operand/result bus and the
// result output stream. slave is the sequencer's view, master the environment's.
interface tensor_core_sequencer_if #(
  parameter int BUS_WIDTH = tensor_core_sequencer_pkg::BUS_WIDTH
);

  logic signed [BUS_WIDTH:0] in_data;
  logic                      in_valid;
  logic                      in_ready;

  logic signed [BUS_WIDTH:0] core_input1 [3][3];
  logic signed [BUS_WIDTH:0] core_input2 [3][3];
  logic [2:0]                core_op_select;
  logic                      core_start;
  logic signed [BUS_WIDTH:0] core_output [3][3];

  logic signed [BUS_WIDTH:0] out_data;
  logic                      out_valid;
  logic                      out_ready;

  logic                      busy;
  logic                      error;

  modport slave (
    input  in_data, in_valid, out_ready, core_output,
    output in_ready, core_input1, core_input2, core_op_select, core_start,
    output out_data, out_valid, busy, error
  );

  modport master (
    output in_data, in_valid, out_ready, core_output,
    input  in_ready, core_input1, core_input2, core_op_select, core_start,
    input  out_data, out_valid, busy, error
  );

endinterface

// File: rtl/tensor_core_result_serializer.sv
// Streams the 3x3 result matrix out row-major, one element per valid/ready
// transfer; the index is cleared whenever the serializer is not enabled.
module tensor_core_result_serializer #(
  parameter int WIDTH = 7
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  i_enable,
  input  logic signed [WIDTH:0] i_matrix [3][3],
  input  logic                  i_outReady,
  output logic signed [WIDTH:0] o_outData,
  output logic                  o_outValid,
  output logic                  o_done
);
  import tensor_core_sequencer_pkg::*;

  logic [3:0] r_elemIdx;
  logic       w_transfer;

  assign w_transfer = i_enable && i_outReady;
  assign o_outValid = i_enable;
  assign o_done     = w_transfer && (r_elemIdx == LAST_ELEM);
  assign o_outData  = i_enable ? i_matrix[elemRow(r_elemIdx)][elemCol(r_elemIdx)] : '0;

  always_ff @(posedge clock_in) begin
    if (reset_in || !i_enable) begin
      r_elemIdx <= 4'd0;
    end else if (w_transfer) begin
      r_elemIdx <= o_done ? 4'd0 : r_elemIdx + 4'd1;
    end
  end

endmodule

// File: rtl/tensor_core_sequencer.sv
// Loads an opcode header and two 3x3 operand matrices from a byte stream,
// pulses the tensor core, waits a fixed compute time, then drains the result.
module tensor_core_sequencer #(
  parameter int BUS_WIDTH      = tensor_core_sequencer_pkg::BUS_WIDTH,
  parameter int COMPUTE_CYCLES = 10
) (
  input logic                    clock_in,
  input logic                    reset_in,
  tensor_core_sequencer_if.slave bus
);
  import tensor_core_sequencer_pkg::*;

  localparam int TIMER_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  seqState_t                 r_state;
  seqState_t                 w_nextState;
  logic [3:0]                r_loadIdx;
  logic [TIMER_W-1:0]        r_timer;
  logic [2:0]                r_opSelect;
  logic signed [BUS_WIDTH:0] r_matA [3][3];
  logic signed [BUS_WIDTH:0] r_matB [3][3];
  logic                      r_error;

  logic w_inReady;
  logic w_accept;
  logic w_headerOk;
  logic w_lastLoad;
  logic w_timerDone;
  logic w_drainEn;
  logic w_drainDone;
  logic w_coreStart;
  logic w_busy;

  // in_ready is forced low during the reset cycle itself
  assign w_inReady   = !reset_in &&
                       ((r_state == IDLE) || (r_state == LOAD_A) || (r_state == LOAD_B));
  assign w_accept    = bus.in_valid && w_inReady;
  assign w_headerOk  = (bus.in_data[2:0] <= OP_RELU);
  assign w_lastLoad  = (r_loadIdx == LAST_ELEM);
  assign w_timerDone = (r_timer == TIMER_W'(COMPUTE_CYCLES - 1));
  assign w_drainEn   = (r_state == DRAIN);

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_coreStart = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (w_accept && w_headerOk) w_nextState = LOAD_A;
      end
      LOAD_A:  if (w_accept && w_lastLoad) w_nextState = LOAD_B;
      LOAD_B:  if (w_accept && w_lastLoad) w_nextState = START;
      START: begin
        w_coreStart = 1'b1;
        w_nextState = COMPUTE;
      end
      COMPUTE: if (w_timerDone) w_nextState = DRAIN;
      DRAIN:   if (w_drainDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operands and opcode are only written while loading, so they stay frozen through compute and drain
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_loadIdx  <= 4'd0;
      r_timer    <= '0;
      r_opSelect <= OP_MATMUL;
      r_error    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          r_matA[i][j] <= '0;
          r_matB[i][j] <= '0;
        end
      end
    end else begin
      r_error <= (r_state == IDLE) && w_accept && !w_headerOk;

      if (w_nextState != r_state) begin
        r_loadIdx <= 4'd0;
        r_timer   <= '0;
      end else begin
        if (((r_state == LOAD_A) || (r_state == LOAD_B)) && w_accept) r_loadIdx <= r_loadIdx + 4'd1;
        if (r_state == COMPUTE) r_timer <= r_timer + 1'b1;
      end

      if ((r_state == IDLE) && w_accept && w_headerOk) r_opSelect <= bus.in_data[2:0];
      if ((r_state == LOAD_A) && w_accept) r_matA[elemRow(r_loadIdx)][elemCol(r_loadIdx)] <= bus.in_data;
      if ((r_state == LOAD_B) && w_accept) r_matB[elemRow(r_loadIdx)][elemCol(r_loadIdx)] <= bus.in_data;
    end
  end

  tensor_core_result_serializer #(
    .WIDTH(BUS_WIDTH)
  ) u_serializer (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .i_enable   (w_drainEn),
    .i_matrix   (bus.core_output),
    .i_outReady (bus.out_ready),
    .o_outData  (bus.out_data),
    .o_outValid (bus.out_valid),
    .o_done     (w_drainDone)
  );

  assign bus.in_ready       = w_inReady;
  assign bus.core_input1    = r_matA;
  assign bus.core_input2    = r_matB;
  assign bus.core_op_select = r_opSelect;
  assign bus.core_start     = w_coreStart;
  assign bus.busy           = w_busy;
  assign bus.error          = r_error;

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Self-checking bench: table of transactions with a result scoreboard, a
// behavioural tensor core that latches its result on core_start, and corner sequences.
module tb_tensor_core_sequencer;
  import tensor_core_sequencer_pkg::*;

  localparam int BW = 7;
  localparam int CC = 10;
  localparam int NVEC = 5;

  logic clock_in = 1'b0;
  logic reset_in = 1'b1;

  tensor_core_sequencer_if #(.BUS_WIDTH(BW)) bus ();

  tensor_core_sequencer #(
    .BUS_WIDTH      (BW),
    .COMPUTE_CYCLES (CC)
  ) dut (
    .clock_in (clock_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  typedef struct {
    logic [7:0]        header;
    logic signed [7:0] a   [9];
    logic signed [7:0] b   [9];
    logic signed [7:0] res [9];
  } vector_t;

  vector_t           vectors [NVEC];
  logic signed [7:0] expQ [$];
  int                compared   = 0;
  int                mismatched = 0;
  bit                slowMode   = 1'b0;
  int                readyPhase = 0;
  int                acc;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Behavioural tensor core: 8-bit wrapping arithmetic, result captured on the start pulse
  always @(posedge clock_in) begin
    if (bus.core_start) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          case (bus.core_op_select)
            3'd0: begin
              acc = 0;
              for (int k = 0; k < 3; k++) acc = acc + int'(bus.core_input1[i][k]) * int'(bus.core_input2[k][j]);
            end
            3'd1:    acc = int'(bus.core_input1[i][j]) + int'(bus.core_input2[i][j]);
            default: acc = (bus.core_input1[i][j] < 0) ? 0 : int'(bus.core_input1[i][j]);
          endcase
          bus.core_output[i][j] <= acc[7:0];
        end
      end
    end
  end

  // out_ready: always high, or low three cycles then high one cycle in slow mode
  always @(posedge clock_in) begin
    #1;
    if (slowMode) begin
      readyPhase = (readyPhase + 1) % 4;
      bus.out_ready = (readyPhase == 3);
    end else begin
      bus.out_ready = 1'b1;
    end
  end

  // Scoreboard: compare on each transfer, and check the element is held while stalled
  always @(negedge clock_in) begin
    if (bus.out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedOutput", int'(bus.out_data), 999);
      end else if (bus.out_ready) begin
        checkOutput("drainData", int'(bus.out_data), int'(expQ.pop_front()));
      end else begin
        checkOutput("drainHold", int'(bus.out_data), int'(expQ[0]));
      end
    end
  end

  task automatic sendByte(input logic [7:0] b, input bit gapped);
    bit ok;
    ok = 1'b0;
    if (gapped) begin
      bus.in_valid = 1'b0;
      @(posedge clock_in); #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clock_in);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock_in); #1;
    end
    if (!ok) checkOutput("inReadyTimeout", 0, 1);
    @(posedge clock_in); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input int vi, input bit gapped);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 9; k++) expQ.push_back(vectors[vi].res[k]);
    sendByte(vectors[vi].header, gapped);
    for (int k = 0; k < 9; k++) sendByte(vectors[vi].a[k], gapped);
    for (int k = 0; k < 9; k++) sendByte(vectors[vi].b[k], gapped);
    checkOutput("startPulse", int'(bus.core_start), 1);
    checkOutput("inReadyAtStart", int'(bus.in_ready), 0);
    @(posedge clock_in); #1;
    checkOutput("startOneCycle", int'(bus.core_start), 0);
    repeat (CC - 1) @(posedge clock_in);
    #1;
    checkOutput("computeLength", int'(bus.out_valid), 0);
    @(posedge clock_in); #1;
    checkOutput("drainEntry", int'(bus.out_valid), 1);
    checkOutput("opHeld", int'(bus.core_op_select), int'(vectors[vi].header[2:0]));
    for (int t = 0; t < 400; t++) begin
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      @(posedge clock_in); #1;
    end
    checkOutput("drainFinished", int'(done), 1);
    checkOutput("scoreboardEmpty", expQ.size(), 0);
    checkOutput("outValidAfterDrain", int'(bus.out_valid), 0);
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nz;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    for (int k = 0; k < 9; k++) begin
      vectors[0].header = 8'd0;
      vectors[0].a[k]   = (k % 4 == 0) ? 8'sd1 : 8'sd0;
      vectors[0].b[k]   = 8'(k + 1);
      vectors[0].res[k] = 8'(k + 1);
      vectors[1].header = 8'd1;
      vectors[1].a[k]   = 8'sd127;
      vectors[1].b[k]   = 8'sd1;
      vectors[1].res[k] = -8'sd128;
      vectors[2].header = 8'd2;
      vectors[2].a[k]   = (k % 2 == 0) ? 8'(-(k + 1)) : 8'(k + 1);
      vectors[2].b[k]   = 8'(3 * k);
      vectors[2].res[k] = (k % 2 == 0) ? 8'sd0 : 8'(k + 1);
      vectors[3].header = 8'd0;
      vectors[3].a[k]   = 8'(k + 1);
      vectors[3].b[k]   = (k % 4 == 0) ? 8'sd1 : 8'sd0;
      vectors[3].res[k] = 8'(k + 1);
      vectors[4].header = 8'd1;
      vectors[4].a[k]   = 8'(10 * k);
      vectors[4].b[k]   = 8'(-20 * k);
      vectors[4].res[k] = 8'(-10 * k);
    end

    // Reset state
    @(posedge clock_in); #1;
    @(posedge clock_in); #1;
    checkOutput("rstInReady", int'(bus.in_ready), 0);
    checkOutput("rstBusy", int'(bus.busy), 0);
    checkOutput("rstCoreStart", int'(bus.core_start), 0);
    checkOutput("rstOutValid", int'(bus.out_valid), 0);
    checkOutput("rstOutData", int'(bus.out_data), 0);
    checkOutput("rstError", int'(bus.error), 0);
    checkOutput("rstOpSelect", int'(bus.core_op_select), 0);
    reset_in = 1'b0;
    @(posedge clock_in); #1;
    checkOutput("inReadyAfterReset", int'(bus.in_ready), 1);

    for (int vi = 0; vi < NVEC; vi++) applyStimulus(vi, 1'b0);

    // Invalid header: one-cycle error, stays idle, opcode untouched
    bus.in_data  = 8'd5;
    bus.in_valid = 1'b1;
    @(posedge clock_in); #1;
    bus.in_valid = 1'b0;
    checkOutput("errorPulse", int'(bus.error), 1);
    checkOutput("errorBusy", int'(bus.busy), 0);
    checkOutput("errorInReady", int'(bus.in_ready), 1);
    checkOutput("errorOpKept", int'(bus.core_op_select), 1);
    @(posedge clock_in); #1;
    checkOutput("errorOneCycle", int'(bus.error), 0);
    checkOutput("errorStillIdle", int'(bus.busy), 0);
    applyStimulus(0, 1'b0);

    // Gapped input and stalled output
    slowMode = 1'b1;
    applyStimulus(0, 1'b1);
    slowMode = 1'b0;

    // Reset landing on the fifth B byte
    sendByte(8'd1, 1'b0);
    for (int k = 0; k < 9; k++) sendByte(8'(k + 20), 1'b0);
    for (int k = 0; k < 4; k++) sendByte(8'(k + 40), 1'b0);
    bus.in_data  = 8'd44;
    bus.in_valid = 1'b1;
    reset_in     = 1'b1;
    @(posedge clock_in); #1;
    checkOutput("midLoadResetBusy", int'(bus.busy), 0);
    checkOutput("midLoadResetInReady", int'(bus.in_ready), 0);
    checkOutput("midLoadResetOp", int'(bus.core_op_select), 0);
    nz = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (bus.core_input1[i][j] != 0 || bus.core_input2[i][j] != 0) nz++;
    checkOutput("midLoadResetMatrices", nz, 0);
    reset_in     = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clock_in); #1;
    checkOutput("inReadyAfterMidReset", int'(bus.in_ready), 1);
    applyStimulus(2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tensor_core_sequencer.md
TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

Interface
REQ-001 Parameter BUS_WIDTH, default 7, SHALL set the element MSB index; elements are BUS_WIDTH+1 = 8 bits signed.
REQ-002 Parameter COMPUTE_CYCLES, default 10, SHALL set the cycles waited after the start pulse before results are read.
REQ-003 clock_in  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset_in  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_data  input  BUS_WIDTH+1  SHALL carry the header or matrix byte.
REQ-006 in_valid  input  1  SHALL mark in_data valid.
REQ-007 in_ready  output  1  SHALL indicate a byte is accepted this cycle when in_valid is also high.
REQ-008 core_input1, core_input2  output  3x3 x BUS_WIDTH+1 signed  SHALL drive the tensor core operand matrices.
REQ-009 core_op_select  output  3  SHALL drive the tensor core matrix_operation_select.
REQ-010 core_start  output  1  SHALL drive the tensor core should_start_tensor_core.
REQ-011 core_output  input  3x3 x BUS_WIDTH+1 signed  SHALL receive the tensor core result matrix.
REQ-012 out_data  output  BUS_WIDTH+1  SHALL carry one result element.
REQ-013 out_valid  output  1; out_ready  input  1  SHALL form the result handshake; transfer when both high.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 error  output  1  SHALL pulse one cycle on an invalid header.

Function
REQ-016 States SHALL be IDLE, LOAD_A, LOAD_B, START, COMPUTE, DRAIN.
REQ-017 in_ready SHALL be high exactly in IDLE, LOAD_A and LOAD_B.
REQ-018 IDLE: accepted header with in_data[2:0] in {0,1,2} SHALL latch core_op_select and go to LOAD_A; values 3..7 SHALL pulse error and stay in IDLE with core_op_select unchanged.
REQ-019 LOAD_A: 9 accepted bytes SHALL fill core_input1 row-major (index k -> [k/3][k%3]); after the 9th go to LOAD_B.
REQ-020 LOAD_B: 9 accepted bytes SHALL fill core_input2 row-major; after the 9th go to START. ReLU (op 2) still requires all 18 bytes.
REQ-021 Cycles with in_valid low SHALL stall loading without losing the element index.
REQ-022 START SHALL last exactly one cycle with core_start high, then go to COMPUTE; core_start SHALL be low in every other state.
REQ-023 COMPUTE SHALL last exactly COMPUTE_CYCLES cycles, then go to DRAIN.
REQ-024 core_input1, core_input2 and core_op_select SHALL hold stable from START until DRAIN exits.
REQ-025 DRAIN: out_valid high; out_data = core_output[k/3][k%3] for k = 0..8; k advances only on transfer; out_data held while out_ready low.
REQ-026 After the 9th transfer, state SHALL return to IDLE with out_valid low next cycle.
REQ-027 Element index SHALL be a 4-bit counter reset to 0 on every state entry; never exceeds 8.
REQ-028 Compute timer SHALL count 0..COMPUTE_CYCLES-1 without wrap; no arithmetic on data bytes.

Reset
REQ-029 Reset SHALL dominate all other events, including mid-load, mid-compute and mid-drain: state IDLE, counters 0.
REQ-030 Reset values: in_ready 0 during the reset cycle then 1; core_input1/2 all 0; core_op_select 0; core_start 0; out_valid 0; out_data 0; busy 0; error 0.

Structure
REQ-031 A shared package SHALL hold the state enum, opcode constants (MATMUL=0, ADD=1, RELU=2) and BUS_WIDTH.
REQ-032 The DRAIN serializer (index counter + 9:1 mux + valid/ready) SHALL be a sub-module tensor_core_result_serializer.

Verification
REQ-033 Header 0, A=identity, B=[1..9], out_ready=1 -> start pulse one cycle after last B byte; out = 1..9.
REQ-034 Header 1, A all 127, B all 1 -> out all -128 (wrap).
REQ-035 Header 2, A=[-1,2,-3,4,-5,6,-7,8,-9] -> out = 0,2,0,4,0,6,0,8,0.
REQ-036 Header 5 -> error for one cycle, busy stays 0, next header 0 accepted normally.
REQ-037 in_valid toggled every other cycle, out_ready low 3 cycles per element -> identical results to REQ-033, no drops or duplicates.
REQ-038 reset_in asserted on the 5th B byte -> next cycle IDLE, matrices 0; fresh full transaction completes correctly.
